// File: rtl/imem_pkg.sv
// Shared types and default sizing for the programmable instruction memory.
package imem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 64;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } imem_state_e;

endpackage

// File: rtl/imem_ram.sv
// Word storage: one synchronous read port, one write port, read-before-write,
// no reset on the array.
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Non-blocking read and write on the same edge returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/prog_imem.sv
// Programmable instruction memory: zero-fill sweep after reset, then
// single-cycle fetches and program writes with alignment/range checking.
module prog_imem
    import imem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic              fetch_fault,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_err,
    output logic              busy
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    imem_state_e      state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             fetch_fault_q, fetch_fault_d;
    logic             fetch_zero_q, fetch_zero_d;
    logic             prog_err_q, prog_err_d;

    logic              in_clear;
    logic              in_run;
    logic              fetch_legal;
    logic              prog_legal;
    logic [IDX_W-1:0]  fetch_idx;
    logic [IDX_W-1:0]  prog_idx;
    logic              fetch_take;
    logic              prog_accept;
    logic              ram_rd_en;
    logic              ram_wr_en;
    logic [IDX_W-1:0]  ram_wr_idx;
    logic [DATA_W-1:0] ram_wr_data;
    logic [DATA_W-1:0] ram_rd_data;

    // Legal = word aligned and below 4*DEPTH, i.e. all bits above the index are zero.
    assign fetch_legal = (fetch_addr[1:0] == 2'b00) && (fetch_addr[ADDR_W-1:IDX_W+2] == '0);
    assign prog_legal  = (prog_addr[1:0] == 2'b00) && (prog_addr[ADDR_W-1:IDX_W+2] == '0);
    assign fetch_idx   = fetch_addr[IDX_W+1:2];
    assign prog_idx    = prog_addr[IDX_W+1:2];

    // Reset is folded in combinationally so nothing is written or accepted while it is high.
    assign in_clear    = (state_q == ST_CLEAR) && !reset;
    assign in_run      = (state_q == ST_RUN) && !reset;
    assign fetch_take  = fetch_req && in_run;
    assign prog_accept = prog_valid && in_run;

    always_comb begin
        state_d       = state_q;
        clr_idx_d     = clr_idx_q;
        fetch_valid_d = fetch_take;
        fetch_fault_d = fetch_take && !fetch_legal;
        fetch_zero_d  = fetch_zero_q;
        prog_err_d    = prog_accept && !prog_legal;

        if (fetch_take) begin
            fetch_zero_d = !fetch_legal;
        end

        if (in_clear) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LAST_IDX) begin
                state_d   = ST_RUN;
                clr_idx_d = '0;
            end
        end
    end

    always_comb begin
        ram_rd_en   = fetch_take && fetch_legal;
        ram_wr_en   = 1'b0;
        ram_wr_idx  = prog_idx;
        ram_wr_data = prog_data;
        if (in_clear) begin
            ram_wr_en   = 1'b1;
            ram_wr_idx  = clr_idx_q;
            ram_wr_data = '0;
        end else if (prog_accept && prog_legal) begin
            ram_wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_CLEAR;
            clr_idx_q     <= '0;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fetch_zero_q  <= 1'b1;
            prog_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_idx_q     <= clr_idx_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_fault_q <= fetch_fault_d;
            fetch_zero_q  <= fetch_zero_d;
            prog_err_q    <= prog_err_d;
        end
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rd_en   (ram_rd_en),
        .rd_idx  (fetch_idx),
        .rd_data (ram_rd_data),
        .wr_en   (ram_wr_en),
        .wr_idx  (ram_wr_idx),
        .wr_data (ram_wr_data)
    );

    // The RAM read register has no reset; a zero flag masks it after reset or a fault.
    assign fetch_data  = fetch_zero_q ? '0 : ram_rd_data;
    assign fetch_valid = fetch_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign prog_err    = prog_err_q;
    assign busy        = reset || (state_q == ST_CLEAR);
    assign prog_ready  = in_run;

endmodule

// File: tb/tb_prog_imem.sv
// Self-checking bench for prog_imem against a word-array reference model.
module tb_prog_imem;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              reset;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic              fetch_fault;
    logic              prog_valid;
    logic              prog_ready;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_err;
    logic              busy;

    prog_imem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .fetch_fault (fetch_fault),
        .prog_valid  (prog_valid),
        .prog_ready  (prog_ready),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_err    (prog_err),
        .busy        (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] last_data;
    bit                model_run;
    int                sweep_cnt;
    int                checks;
    int                fails;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [ADDR_W-1:0] a);
        return (a % 4 == 0) && (a < 4 * DEPTH);
    endfunction

    task automatic model_reset();
        model_run = 0;
        sweep_cnt = 0;
        last_data = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // Holds reset for a few edges, checking the forced values, then releases after an edge.
    task automatic apply_reset();
        reset      = 1'b1;
        fetch_req  = 1'b0;
        prog_valid = 1'b0;
        fetch_addr = '0;
        prog_addr  = '0;
        prog_data  = '0;
        model_reset();
        #2;
        check("rst_fetch_valid", fetch_valid, 0);
        check("rst_fetch_fault", fetch_fault, 0);
        check("rst_fetch_data", fetch_data, 0);
        check("rst_prog_err", prog_err, 0);
        check("rst_busy", busy, 1);
        check("rst_prog_ready", prog_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock: drive inputs, predict, advance, compare registered results.
    task automatic do_cycle(input logic freq, input logic [ADDR_W-1:0] faddr,
                            input logic pv, input logic [ADDR_W-1:0] paddr,
                            input logic [DATA_W-1:0] pdata);
        logic              exp_valid;
        logic              exp_fault;
        logic              exp_err;
        logic [DATA_W-1:0] exp_data;
        logic [DATA_W-1:0] got_exp;
        fetch_req  = freq;
        fetch_addr = faddr;
        prog_valid = pv;
        prog_addr  = paddr;
        prog_data  = pdata;
        check("busy", busy, !model_run);
        check("prog_ready", prog_ready, model_run);
        exp_valid = freq && model_run;
        exp_fault = exp_valid && !legal(faddr);
        if (exp_valid) exp_data = legal(faddr) ? model_mem[faddr[ADDR_W-1:2]] : '0;
        else           exp_data = last_data;
        exp_q.push_back(exp_data);
        exp_err = pv && model_run && !legal(paddr);
        if (pv && model_run && legal(paddr)) model_mem[paddr[ADDR_W-1:2]] = pdata;
        @(posedge clk);
        #1;
        if (!model_run) begin
            sweep_cnt++;
            if (sweep_cnt == DEPTH) model_run = 1;
        end
        got_exp = exp_q.pop_front();
        check("fetch_valid", fetch_valid, exp_valid);
        check("fetch_fault", fetch_fault, exp_fault);
        check("fetch_data", fetch_data, got_exp);
        check("prog_err", prog_err, exp_err);
        last_data = got_exp;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a);
        do_cycle(1'b1, a, 1'b0, '0, '0);
    endtask

    task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        do_cycle(1'b0, '0, 1'b1, a, d);
    endtask

    task automatic run_sweep();
        for (int i = 0; i < DEPTH; i++) fetch('0);
    endtask

    initial begin
        logic [ADDR_W-1:0] fa;
        logic [ADDR_W-1:0] pa;
        int                r;
        checks = 0;
        fails  = 0;
        reset  = 1'b0;
        #1;
        apply_reset();

        // Sweep with continuous fetch requests, then first fetch sees zero.
        run_sweep();
        check("sweep_done", {31'b0, model_run}, 1);
        fetch(32'h0);

        // Program two words, fetch back-to-back.
        write(32'h0, 32'hE280_0016);
        write(32'h4, 32'hE281_1037);
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h4);

        // Misaligned and out-of-range fetches.
        fetch(32'h2);
        fetch(32'h100);
        do_cycle(1'b0, '0, 1'b0, '0, '0);

        // Illegal write: error pulse, then full scan shows memory unchanged.
        write(32'h101, 32'hFFFF_FFFF);
        do_cycle(1'b0, '0, 1'b0, '0, '0);
        fetch(32'h100);
        for (int i = 0; i < DEPTH; i++) fetch(ADDR_W'(4 * i));

        // Read-before-write on the same word.
        write(32'hC, 32'h1111_1111);
        do_cycle(1'b1, 32'hC, 1'b1, 32'hC, 32'h2222_2222);
        fetch(32'hC);

        // Randomized mixed traffic.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       fa = ADDR_W'($urandom_range(0, DEPTH - 1) * 4);
            else if (r == 7) fa = ADDR_W'($urandom_range(0, 4 * DEPTH - 1)) | 32'h1;
            else if (r == 8) fa = ADDR_W'($urandom_range(4 * DEPTH, 4 * DEPTH + 64));
            else             fa = $urandom;
            r = $urandom_range(0, 9);
            if (r < 8)       pa = ADDR_W'($urandom_range(0, DEPTH - 1) * 4);
            else if (r == 8) pa = ADDR_W'($urandom_range(0, 4 * DEPTH - 1)) | 32'h2;
            else             pa = ADDR_W'($urandom_range(4 * DEPTH, 8 * DEPTH));
            do_cycle(1'($urandom_range(0, 1)), fa, 1'($urandom_range(0, 1)), pa, $urandom);
        end

        // Reset in RUN, then again mid-sweep: full restart and word 5 cleared.
        write(32'h14, 32'hDEAD_BEEF);
        fetch(32'h14);
        apply_reset();
        for (int i = 0; i < 10; i++) fetch(32'h14);
        apply_reset();
        run_sweep();
        fetch(32'h14);
        fetch(32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
